// File: rtl/display_mux_controller.sv
// Two-digit time-multiplexed seven-segment controller with dead-time gaps between digits.
// Every output is a register; the next-state decode only ever feeds those registers.
module display_mux_controller #(
   parameter int REFRESH_DIV = 48000,
   parameter int DEADTIME    = 480
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] digit0,
   input  logic [3:0] digit1,
   output logic [3:0] hex_sel,
   output logic [1:0] anode,
   output logic       digit_sel,
   output logic       frame_tick
);

   localparam int MAX_LEN_A = (REFRESH_DIV > DEADTIME) ? REFRESH_DIV : DEADTIME;
   localparam int MAX_LEN   = (MAX_LEN_A > 1) ? MAX_LEN_A : 1;
   localparam int CW        = $clog2(MAX_LEN) + 1;
   localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
   // A zero-length gap must never be compared against a negative terminal count.
   localparam logic [CW-1:0] GAP_LAST  = (DEADTIME > 0) ? CW'(DEADTIME - 1) : {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam bit            SKIP_GAP  = (DEADTIME == 0);

   typedef enum logic [1:0] {
      SHOW0 = 2'd0,
      GAP0  = 2'd1,
      SHOW1 = 2'd2,
      GAP1  = 2'd3
   } state_t;

   state_t          state_r;
   state_t          next_s;
   logic [CW-1:0]   cnt_r;
   logic [1:0]      anode_next_s;
   logic            tick_next_s;
   logic            load1_s;
   logic            load0_s;

   // Next-state selection and decode of the values loaded into the output registers.
   always_comb begin
      next_s       = state_r;
      anode_next_s = 2'b11;
      case (state_r)
         SHOW0: begin
            if (cnt_r == SHOW_LAST) begin
               next_s = SKIP_GAP ? SHOW1 : GAP0;
            end else begin
               next_s = SHOW0;
            end
         end
         GAP0: begin
            if (cnt_r == GAP_LAST) begin
               next_s = SHOW1;
            end else begin
               next_s = GAP0;
            end
         end
         SHOW1: begin
            if (cnt_r == SHOW_LAST) begin
               next_s = SKIP_GAP ? SHOW0 : GAP1;
            end else begin
               next_s = SHOW1;
            end
         end
         GAP1: begin
            if (cnt_r == GAP_LAST) begin
               next_s = SHOW0;
            end else begin
               next_s = GAP1;
            end
         end
         default: next_s = GAP1;
      endcase
      case (next_s)
         SHOW0:   anode_next_s = 2'b10;
         SHOW1:   anode_next_s = 2'b01;
         default: anode_next_s = 2'b11;
      endcase
      load1_s     = (next_s == GAP0) || ((next_s == SHOW1) && (state_r != SHOW1));
      load0_s     = (next_s == GAP1) || ((next_s == SHOW0) && (state_r != SHOW0));
      tick_next_s = (next_s == SHOW0) && (state_r != SHOW0);
   end

   // Sequencer state, slot counter and registered outputs; disable freezes and blanks.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= GAP1;
         cnt_r      <= {CW{1'b0}};
         anode      <= 2'b11;
         hex_sel    <= 4'h0;
         digit_sel  <= 1'b0;
         frame_tick <= 1'b0;
      end else if (enable) begin
         state_r <= next_s;
         if (next_s != state_r) begin
            cnt_r <= {CW{1'b0}};
         end else begin
            cnt_r <= cnt_r + CNT_ONE;
         end
         anode      <= anode_next_s;
         frame_tick <= tick_next_s;
         if (load1_s) begin
            hex_sel   <= digit1;
            digit_sel <= 1'b1;
         end else if (load0_s) begin
            hex_sel   <= digit0;
            digit_sel <= 1'b0;
         end else begin
            hex_sel   <= hex_sel;
            digit_sel <= digit_sel;
         end
      end else begin
         anode      <= 2'b11;
         frame_tick <= 1'b0;
      end
   end

endmodule

// File: tb/tb_display_mux_controller.sv
// Bench for display_mux_controller: three parameterisations against a frame-position model,
// directed scenarios followed by randomized enable/reset/digit traffic.
module tb_display_mux_controller;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [3:0] digit0;
   logic [3:0] digit1;
   logic [3:0] hex0, hex1, hex2;
   logic [1:0] an0, an1, an2;
   logic       sel0, sel1, sel2;
   logic       ft0, ft1, ft2;

   int checks = 0;
   int errors = 0;

   // Model state per DUT: position inside the 2*(R+D) frame plus a post-reset flag.
   int         mpos [3];
   bit         mrg  [3];
   logic [1:0] ean  [3];
   logic [3:0] ehex [3];
   logic       esel [3];
   logic       eft  [3];

   display_mux_controller #(.REFRESH_DIV(4), .DEADTIME(1)) u_dut0 (
      .clk(clk), .reset(reset), .enable(enable), .digit0(digit0), .digit1(digit1),
      .hex_sel(hex0), .anode(an0), .digit_sel(sel0), .frame_tick(ft0));
   display_mux_controller #(.REFRESH_DIV(2), .DEADTIME(0)) u_dut1 (
      .clk(clk), .reset(reset), .enable(enable), .digit0(digit0), .digit1(digit1),
      .hex_sel(hex1), .anode(an1), .digit_sel(sel1), .frame_tick(ft1));
   display_mux_controller #(.REFRESH_DIV(3), .DEADTIME(2)) u_dut2 (
      .clk(clk), .reset(reset), .enable(enable), .digit0(digit0), .digit1(digit1),
      .hex_sel(hex2), .anode(an2), .digit_sel(sel2), .frame_tick(ft2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int get_r(input int k);
      case (k)
         0:       return 4;
         1:       return 2;
         default: return 3;
      endcase
   endfunction

   function automatic int get_d(input int k);
      case (k)
         0:       return 1;
         1:       return 0;
         default: return 2;
      endcase
   endfunction

   // 0 = SHOW0, 1 = GAP0, 2 = SHOW1, 3 = GAP1
   function automatic int region(input int p, input int r, input int d);
      if (p < r) return 0;
      else if (p < r + d) return 1;
      else if (p < 2 * r + d) return 2;
      else return 3;
   endfunction

   task automatic model_update(input int k, input logic r_v, input logic e_v,
                               input logic [3:0] d0, input logic [3:0] d1);
      int r, d, p, old_reg, np, nr;
      r = get_r(k);
      d = get_d(k);
      p = 2 * (r + d);
      if (!r_v) begin
         mpos[k] = 2 * r + d;
         mrg[k]  = 1'b1;
         ean[k]  = 2'b11;
         ehex[k] = 4'h0;
         esel[k] = 1'b0;
         eft[k]  = 1'b0;
      end else if (!e_v) begin
         ean[k] = 2'b11;
         eft[k] = 1'b0;
      end else begin
         old_reg = mrg[k] ? 3 : region(mpos[k], r, d);
         if (mrg[k]) np = (d == 0) ? 0 : (2 * r + d + 1) % p;
         else np = (mpos[k] + 1) % p;
         nr = region(np, r, d);
         mrg[k]  = 1'b0;
         mpos[k] = np;
         ean[k]  = (nr == 0) ? 2'b10 : ((nr == 2) ? 2'b01 : 2'b11);
         eft[k]  = (nr == 0) && (old_reg != 0);
         if (nr == 1 || (nr == 2 && old_reg != 2)) begin
            ehex[k] = d1;
            esel[k] = 1'b1;
         end else if (nr == 3 || (nr == 0 && old_reg != 0)) begin
            ehex[k] = d0;
            esel[k] = 1'b0;
         end
      end
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare(input int k);
      logic [1:0] a;
      logic [3:0] h;
      logic       s;
      logic       f;
      case (k)
         0:       begin a = an0; h = hex0; s = sel0; f = ft0; end
         1:       begin a = an1; h = hex1; s = sel1; f = ft1; end
         default: begin a = an2; h = hex2; s = sel2; f = ft2; end
      endcase
      check($sformatf("dut%0d_anode", k), {6'd0, a}, {6'd0, ean[k]});
      check($sformatf("dut%0d_hex_sel", k), {4'd0, h}, {4'd0, ehex[k]});
      check($sformatf("dut%0d_digit_sel", k), {7'd0, s}, {7'd0, esel[k]});
      check($sformatf("dut%0d_frame_tick", k), {7'd0, f}, {7'd0, eft[k]});
      check($sformatf("dut%0d_anode_not_00", k), {7'd0, (a != 2'b00)}, 8'd1);
   endtask

   task automatic step(input logic r_v, input logic e_v);
      reset  = r_v;
      enable = e_v;
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_update(k, r_v, e_v, digit0, digit1);
      @(negedge clk);
      for (int k = 0; k < 3; k++) compare(k);
   endtask

   initial begin
      logic [1:0] an27 [11];
      logic [3:0] hx27 [11];
      logic       ft27 [11];
      an27 = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b10};
      hx27 = '{4'h3, 4'h3, 4'h3, 4'h3, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'h3, 4'h3};
      ft27 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      digit0 = 4'h3;
      digit1 = 4'hA;
      reset  = 1'b0;
      enable = 1'b1;
      @(negedge clk);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      check("reset_anode", {6'd0, an0}, 8'h03);
      check("reset_hex_sel", {4'd0, hex0}, 8'h00);

      // Reference period for R=4/D=1 and the gapless R=2/D=0 sequence.
      for (int i = 0; i < 11; i++) begin
         step(1'b1, 1'b1);
         check("period_anode", {6'd0, an0}, {6'd0, an27[i]});
         check("period_hex_sel", {4'd0, hex0}, {4'd0, hx27[i]});
         check("period_frame_tick", {7'd0, ft0}, {7'd0, ft27[i]});
         check("nogap_anode", {6'd0, an1}, ((i / 2) % 2 == 0) ? 8'h02 : 8'h01);
         check("nogap_hex_sel", {4'd0, hex1}, ((i / 2) % 2 == 0) ? 8'h03 : 8'h0A);
      end

      // dut0 sits at frame position 0; change digit0 inside SHOW0.
      digit0 = 4'h7;
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      check("midshow_hold_hex", {4'd0, hex0}, 8'h03);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
      check("gap1_load_hex", {4'd0, hex0}, 8'h07);
      check("gap1_anode", {6'd0, an0}, 8'h03);
      step(1'b1, 1'b1);

      // Freeze five cycles in the middle of SHOW1.
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
      check("show1_before_freeze", {6'd0, an0}, 8'h01);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0);
         check("freeze_anode", {6'd0, an0}, 8'h03);
         check("freeze_hex_sel", {4'd0, hex0}, 8'h0A);
         check("freeze_frame_tick", {7'd0, ft0}, 8'h00);
      end
      step(1'b1, 1'b1);
      check("resume_anode_a", {6'd0, an0}, 8'h01);
      step(1'b1, 1'b1);
      check("resume_anode_b", {6'd0, an0}, 8'h01);
      step(1'b1, 1'b1);
      check("resume_gap_anode", {6'd0, an0}, 8'h03);

      // Reset pulse inside SHOW0, then restart.
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      check("pre_reset_anode", {6'd0, an0}, 8'h02);
      step(1'b0, 1'b1);
      check("midreset_anode", {6'd0, an0}, 8'h03);
      check("midreset_hex_sel", {4'd0, hex0}, 8'h00);
      check("midreset_digit_sel", {7'd0, sel0}, 8'h00);
      step(1'b1, 1'b1);
      check("restart_anode", {6'd0, an0}, 8'h02);
      check("restart_frame_tick", {7'd0, ft0}, 8'h01);
      check("restart_hex_sel", {4'd0, hex0}, 8'h07);
      check("restart_nogap_tick", {7'd0, ft1}, 8'h01);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) begin
            digit0 = 4'($urandom_range(15));
            digit1 = 4'($urandom_range(15));
         end
         step(($urandom_range(63) == 0) ? 1'b0 : 1'b1,
              ($urandom_range(7) == 0) ? 1'b0 : 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/display_mux_controller.md
DISPLAY_MUX_CONTROLLER -- requirements
Module: display_mux_controller

Interface
REQ-001 Parameter REFRESH_DIV, default 48000: enabled clock cycles each digit is lit (SHOW slot); SHALL be >= 1.
REQ-002 Parameter DEADTIME, default 480: enabled clock cycles both digits are dark between SHOW slots (GAP slot); SHALL be >= 0.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-005 Port enable  input  1  1 = multiplex/count; 0 = freeze sequencing and blank the display.
REQ-006 Port digit0  input  4  hex value for digit 0 (right digit).
REQ-007 Port digit1  input  4  hex value for digit 1 (left digit).
REQ-008 Port hex_sel  output  4  value driven into the single shared seven-segment decoder.
REQ-009 Port anode  output  2  active-low digit enables: bit0 = digit 0, bit1 = digit 1.
REQ-010 Port digit_sel  output  1  index of the digit whose value hex_sel currently holds.
REQ-011 Port frame_tick  output  1  one-cycle pulse on each entry into SHOW0.

Function
REQ-012 FSM states SHOW0, GAP0, SHOW1, GAP1; order SHOW0 -> GAP0 -> SHOW1 -> GAP1 -> SHOW0.
REQ-013 Slot counter, width $clog2(max(REFRESH_DIV, DEADTIME, 1)) + 1, counts enabled edges within a state; the state advances on the enabled edge at which counter == slot length - 1; counter clears to 0 on every state change.
REQ-014 SHOW slot length = REFRESH_DIV; GAP slot length = DEADTIME; with DEADTIME = 0, GAP states are skipped (SHOW0 -> SHOW1 -> SHOW0).
REQ-015 Full period = 2*(REFRESH_DIV + DEADTIME) enabled cycles.
REQ-016 All outputs are registered or decoded only from registers; no combinational path from any input to any output.
REQ-017 anode = 2'b10 in SHOW0, 2'b01 in SHOW1, 2'b11 in GAP0/GAP1; 2'b00 never occurs.
REQ-018 hex_sel <= digit1, digit_sel <= 1 on every enabled edge whose next state is GAP0, or SHOW1 entered from any other state.
REQ-019 hex_sel <= digit0, digit_sel <= 0 on every enabled edge whose next state is GAP1, or SHOW0 entered from any other state.
REQ-020 hex_sel and digit_sel hold throughout a SHOW slot; digit input changes during SHOW are not displayed until the next load.
REQ-021 frame_tick = 1 for exactly the first cycle of each SHOW0 slot, else 0.
REQ-022 enable = 0 on an edge: state, counter, hex_sel, digit_sel hold; anode = 2'b11 after that edge; frame_tick = 0.
REQ-023 enable returning to 1: anode shows the state-decoded value after the next edge; counting resumes from the frozen counter value (no slot restart, no extra frame_tick).

Reset
REQ-024 reset = 0 on an edge, regardless of enable or state: state = GAP1, counter = 0, anode = 2'b11, hex_sel = 4'h0, digit_sel = 0, frame_tick = 0.
REQ-025 Reset asserted mid-SHOW blanks anode on the same edge; no partial-slot residue after release.
REQ-026 First enabled edge after release: DEADTIME >= 1 counts GAP1 normally (loading digit0); DEADTIME = 0 enters SHOW0 directly with hex_sel = digit0 and frame_tick = 1.

Verification
REQ-027 REFRESH_DIV=4, DEADTIME=1, enable=1, digit0=4'h3, digit1=4'hA, reset released -> after edge 1: anode=10, hex_sel=3, frame_tick=1; after edges 1-4 anode=10; edge 5 anode=11, hex_sel=A; edges 6-9 anode=01; edge 10 anode=11, hex_sel=3; edge 11 anode=10, frame_tick=1 (period 10).
REQ-028 DEADTIME=0, REFRESH_DIV=2 -> anode sequence 10,10,01,01,10... with no 11 cycles; hex_sel toggles 3/A at slot edges, same edges as anode.
REQ-029 Change digit0 from 3 to 7 mid-SHOW0 -> hex_sel stays 3 until the next GAP1/SHOW0 load, then 7.
REQ-030 enable=0 for 5 cycles mid-SHOW1 -> anode=11 for those cycles, hex_sel=A held, no frame_tick; on re-enable SHOW1 completes only its remaining cycles.
REQ-031 reset=0 for one edge mid-SHOW0 -> next outputs anode=11, hex_sel=0, digit_sel=0; sequencing restarts per REQ-026.
REQ-032 All cycles: assert anode != 2'b00, frame_tick width 1, and hex_sel unchanged whenever anode != 2'b11 is held across consecutive cycles.
